// File: rtl/st_if.sv
// Bus bundle for the st store unit: request handshake from the sequencer
// plus the synchronous single-port memory read/write strobes.
interface st_if;
  logic        start;
  logic        stop;
  logic        fault;
  logic [5:0]  field;
  logic [30:0] in;
  logic        mem_re;
  logic [30:0] mem_rdata;
  logic        mem_we;
  logic [30:0] mem_wdata;

  modport master (output start, field, in, mem_rdata,
                  input  stop, fault, mem_re, mem_we, mem_wdata);
  modport slave  (input  start, field, in, mem_rdata,
                  output stop, fault, mem_re, mem_we, mem_wdata);
endinterface

// File: rtl/st.sv
// MIX store unit: replaces field (L:R) of a memory word by read-modify-write.
// Optional ST_FULLWORD_BYPASS_EN skips the read for the full-word field (0:5).
module st (
  input  logic clk,
  input  logic rst,
  st_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  state_t      state, nxt;
  logic [5:0]  fld;
  logic [30:0] word;
  logic [30:0] merged;
  logic        valid_in;
  logic        accept;
  int          lv, rv, lpv;

  assign valid_in = (bus.field[5:3] <= bus.field[2:0]) && (bus.field[2:0] <= 3'd5);
  assign accept   = (state == IDLE) && bus.start;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.start) begin
        if (!valid_in) nxt = DONE;
`ifdef ST_FULLWORD_BYPASS_EN
        else if (bus.field == 6'd5) nxt = WRITE;
`endif
        else nxt = READ;
      end
      READ:    nxt = MERGE;
      MERGE:   nxt = WRITE;
      WRITE:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Memory byte b (L'..R) takes register byte 5-(R-b), so the rightmost
  // register bytes land in the field with their order preserved.
  always_comb begin
    lv     = int'(fld[5:3]);
    rv     = int'(fld[2:0]);
    lpv    = (lv == 0) ? 1 : lv;
    merged = bus.mem_rdata;
    if (lv == 0) merged[30] = word[30];
    for (int b = 1; b <= 5; b++) begin
      if (b >= lpv && b <= rv)
        merged[35-6*b -: 6] = word[35-6*(5-rv+b) -: 6];
    end
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      fld           <= '0;
      word          <= '0;
      bus.stop      <= 1'b0;
      bus.fault     <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      state      <= nxt;
      bus.mem_re <= (nxt == READ);
      bus.mem_we <= (nxt == WRITE);
      bus.stop   <= (nxt == DONE);
      bus.fault  <= accept && !valid_in;
      if (accept) begin
        fld  <= bus.field;
        word <= bus.in;
      end
      if (state == MERGE) bus.mem_wdata <= merged;
`ifdef ST_FULLWORD_BYPASS_EN
      if (accept && bus.field == 6'd5) bus.mem_wdata <= bus.in;
`endif
    end
  end
endmodule

// File: tb/tb_st.sv
// Scoreboard bench for st: stimulus pushes expected completions, a negedge
// monitor pops them on stop and checks fault, memory word, latency, strobes.
module tb_st;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  st_if bus();
  st dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    string       name;
    logic        fault;
    logic [30:0] word;
    int          t0;
    int          lat;
    int          nre;
    int          nwe;
  } exp_t;

  exp_t        q[$];
  int          errs = 0, checks = 0, cyc = 0, nre = 0, nwe = 0;
  logic [30:0] mem, pre_val;
  logic        pre_en = 1'b0;

`ifdef ST_FULLWORD_BYPASS_EN
  localparam int FW_LAT = 2, FW_RE = 0;
`else
  localparam int FW_LAT = 4, FW_RE = 1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_en) mem <= pre_val;
    else if (bus.mem_we) mem <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem;
  end

  function automatic logic [30:0] w(bit s, int b1, int b2, int b3, int b4, int b5);
    return {s, 6'(b1), 6'(b2), 6'(b3), 6'(b4), 6'(b5)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      nre = 0;
      nwe = 0;
    end else begin
      if (bus.mem_re | bus.mem_we) chk("re_we_excl", 32'(bus.mem_re & bus.mem_we), 0);
      if (bus.fault && !bus.stop) chk("fault_without_stop", 32'(bus.stop), 1);
      if (bus.mem_re) nre++;
      if (bus.mem_we) nwe++;
      if (bus.stop) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_stop: got stop at cycle %0d want none", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_fault"}, 32'(bus.fault), 32'(e.fault));
          chk({e.name, "_mem"}, 32'(mem), 32'(e.word));
          chk({e.name, "_lat"}, cyc - e.t0, e.lat);
          chk({e.name, "_nre"}, nre, e.nre);
          chk({e.name, "_nwe"}, nwe, e.nwe);
        end
        nre = 0;
        nwe = 0;
      end
    end
  end

  task automatic preload(logic [30:0] v);
    @(posedge clk) #1;
    pre_en  = 1'b1;
    pre_val = v;
    @(posedge clk) #1;
    pre_en  = 1'b0;
  endtask

  // Issues one start (held for 'hold' extra cycles with a junk field) and
  // waits for the stop cycle; returns #1 into the stop cycle.
  task automatic run(string nm, logic [5:0] f, logic [30:0] inw, logic [30:0] expw,
                     logic ef, int elat, int ere, int ewe, int hold);
    int n;
    bus.field = f;
    bus.in    = inw;
    bus.start = 1'b1;
    q.push_back('{nm, ef, expw, cyc, elat, ere, ewe});
    @(posedge clk) #1;
    bus.field = 6'o32;
    bus.in    = w(1, 63, 63, 63, 63, 63);
    repeat (hold) @(posedge clk) #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.stop && n < 20) begin
      @(posedge clk) #1;
      n++;
    end
    if (!bus.stop) begin
      checks++;
      errs++;
      $display("FAIL %s_timeout: got no stop want stop within 20 cycles", nm);
      void'(q.pop_front());
    end
  endtask

  initial begin
    logic [30:0] base, src;
    base = w(1, 1, 2, 3, 4, 5);
    src  = w(0, 6, 7, 8, 9, 0);
    bus.start = 1'b0;
    bus.field = '0;
    bus.in    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.stop, bus.fault, bus.mem_re, bus.mem_we},
        4'b0);
    chk("reset_wdata", 32'(bus.mem_wdata), 0);
    rst = 1'b0;

    preload(base); run("f05", 6'o05, src, w(0, 6, 7, 8, 9, 0), 0, FW_LAT, FW_RE, 1, 0);
    preload(base); run("f15", 6'o15, src, w(1, 6, 7, 8, 9, 0), 0, 4, 1, 1, 0);
    preload(base); run("f55", 6'o55, src, w(1, 1, 2, 3, 4, 0), 0, 4, 1, 1, 0);
    preload(base); run("f22", 6'o22, src, w(1, 1, 0, 3, 4, 5), 0, 4, 1, 1, 0);
    preload(base); run("f23", 6'o23, src, w(1, 1, 9, 0, 4, 5), 0, 4, 1, 1, 0);
    preload(base); run("f01", 6'o01, src, w(0, 0, 2, 3, 4, 5), 0, 4, 1, 1, 0);
    preload(base); run("f00", 6'o00, src, w(0, 1, 2, 3, 4, 5), 0, 4, 1, 1, 0);
    preload(base); run("f32", 6'o32, src, base, 1, 1, 0, 0, 0);
    preload(base); run("f06", 6'o06, src, base, 1, 1, 0, 0, 0);
    preload(base); run("f07", 6'o07, src, base, 1, 1, 0, 0, 0);
    preload(base); run("f16", 6'o16, src, base, 1, 1, 0, 0, 0);

    // Overlapping starts ignored, then a back-to-back store in the cycle after stop.
    preload(base);
    run("b2b_11", 6'o11, src, w(1, 0, 2, 3, 4, 5), 0, 4, 1, 1, 3);
    @(posedge clk) #1;
    run("b2b_55", 6'o55, src, w(1, 0, 2, 3, 4, 0), 0, 4, 1, 1, 0);

    // Reset while in MERGE must abort before the write.
    preload(base);
    bus.field = 6'o15;
    bus.in    = src;
    bus.start = 1'b1;
    @(posedge clk) #1;
    bus.start = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {bus.stop, bus.fault, bus.mem_re, bus.mem_we}, 4'b0);
    chk("abort_wdata", 32'(bus.mem_wdata), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      chk("post_abort_outputs", {bus.stop, bus.fault, bus.mem_re, bus.mem_we}, 4'b0);
    end
    chk("post_abort_wdata", 32'(bus.mem_wdata), 0);
    chk("post_abort_mem", 32'(mem), 32'(base));
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/st.md
# st

Store unit for MIX STA/STX/ST1–ST6/STJ/STZ (opcodes 24–33) and the write-side counterpart of the field-load unit. It replaces field (L:R) of a memory word with the rightmost bytes of a register word by read-modify-write over a synchronous memory port. It sits beside the load unit under the control sequencer. The core drives the memory address, selects the source register, and supplies zero for STZ and the +0:0:0:J-address word for STJ.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- stop  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle pulse coincident with stop when the field is invalid.
- field  in  6  F = 8*L+R; L = field[5:3], R = field[2:0]; sampled with start.
- in  in  31  source register word; bit 30 is the sign, byte1 = [29:24] … byte5 = [5:0]; sampled with start.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  31  memory word, valid the cycle after mem_re.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  31  merged word; valid whenever mem_we=1.

## Operation
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE + start: latch field and in.
  - Valid field (L≤R, R≤5): go to READ.
  - Invalid field: go to DONE with the fault flag set; no memory access occurs.
- READ: mem_re=1 for exactly one cycle; go to MERGE.
- MERGE: compute and register mem_wdata from mem_rdata and the latched word; go to WRITE.
  - If L=0: sign ← in[30]; otherwise memory sign is kept.
  - L' = max(L,1). If R≥L', memory bytes L'..R ← register bytes (5−(R−L'))..5, order preserved.
  - All other bytes are unchanged.
- WRITE: mem_we=1 for one cycle; go to DONE.
- DONE: stop=1, fault=flag, for one cycle; go to IDLE.
- start outside IDLE is ignored; no queuing.
- (0:0) is valid: it writes only the sign. L=0 with R=0 touches no bytes.

## Timing
- Reset values: stop=0, fault=0, mem_re=0, mem_we=0, mem_wdata=0, state IDLE, latched field/in=0.
- Start sampled at cycle T; mem_re at T+1; mem_rdata sampled at T+2; mem_we at T+3; stop at T+4.
- Invalid field: stop=fault=1 at T+1.
- mem_re and mem_we are never high in the same cycle. Each is high at most once per operation.
- Back-to-back: start is accepted in the cycle after stop, i.e. once the block is back in IDLE.
- Reset mid-operation aborts at once: mem_we and mem_re drop asynchronously, no stop is produced, and a partially merged word is never written.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ST_FULLWORD_BYPASS_EN defined, field=5 (0:5): IDLE → WRITE directly, with mem_wdata ← in. Timing is mem_we at T+1 and stop at T+2, with no mem_re.
- ST_FULLWORD_BYPASS_EN undefined: (0:5) takes the normal 4-cycle read-modify-write path. Results are bit-identical; only latency differs.

## Test plan
Memory preloaded with −1 2 3 4 5; in = +6 7 8 9 0 (byte values decimal).
- Field (0:5) → write +6 7 8 9 0; stop at T+4, or T+2 with no mem_re when bypass is enabled.
- Fields (1:5) → −6 7 8 9 0; (5:5) → −1 2 3 4 0; (2:2) → −1 0 3 4 5. Each case starts from a fresh preload.
- Fields (2:3) → −1 9 0 4 5; (0:1) → +0 2 3 4 5; (0:0) → +1 2 3 4 5.
- Field (3:2), or R=6/7 → stop=fault=1 at T+1; mem_re and mem_we stay 0 throughout; memory is unchanged.
- Overlap: start re-asserted at T+1..T+3 is ignored. Two back-to-back stores, (1:1) then (5:5), on −1 2 3 4 5 → −0 2 3 4 5, then −0 2 3 4 0.
- Assert rst in the cycle before WRITE → mem_we never pulses, memory keeps −1 2 3 4 5, and all outputs are 0 during reset and after release.
